pipelined_rca: RTL and testbench

//   Parametrised, pipelined ripple-carry adder/subtractor for the multiplier datapath.

---
 rtl/arith_pkg.sv | 18 +
 rtl/rca_chunk.sv | 34 +++
 rtl/pipelined_rca.sv | 128 ++++++++++++
 tb/tb_pipelined_rca.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic constants and helpers
// for the pipelined adder datapath.
package arith_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;

   function automatic int chunk_w(input int width, input int stages);
      return width / stages;
   endfunction

   // One full adder: returns {carry, sum}.
   function automatic logic [1:0] fa(input logic x, input logic y,
                                     input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple-carry chunk built
// from single-bit full adders.
module rca_chunk
   import arith_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_i,
   output logic [CHUNK-1:0] s,
   output logic             c_o,
   output logic             c_msb
);

   logic       cy;
   logic [1:0] r;

   // Ripple the carry bit by bit; c_msb is the carry into the top bit.
   always_comb begin
      cy    = c_i;
      s     = '0;
      c_msb = 1'b0;
      r     = '0;
      for (int i = 0; i < CHUNK; i++) begin
         c_msb = cy;
         r     = fa(a[i], b[i], cy);
         s[i]  = r[0];
         cy    = r[1];
      end
      c_o = cy;
   end

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor:
// one chunk per stage, carries registered between stages.
module pipelined_rca
   import arith_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_i,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_o,
   output logic             ovf
);

   localparam int CW = chunk_w(WIDTH, STAGES);
   localparam int L  = STAGES - 1;

   if (WIDTH % STAGES != 0) begin : g_chk
      $error("pipelined_rca: WIDTH must be divisible by STAGES");
   end

   logic               en;
   logic [STAGES-1:0]  vld_q, vld_d;
   logic [STAGES-1:0]  cy_q, cy_d;
   logic               cmsb_q, cmsb_d;
   logic [WIDTH-1:0]   sum_q [STAGES];
   logic [WIDTH-1:0]   sum_d [STAGES];
   logic [WIDTH-1:0]   a_q   [STAGES];
   logic [WIDTH-1:0]   a_d   [STAGES];
   logic [WIDTH-1:0]   b_q   [STAGES];
   logic [WIDTH-1:0]   b_d   [STAGES];

   logic [WIDTH-1:0]   a_src [STAGES];
   logic [WIDTH-1:0]   b_src [STAGES];
   logic [WIDTH-1:0]   s_src [STAGES];
   logic [STAGES-1:0]  c_src, v_src;
   logic [CW-1:0]      ch_s  [STAGES];
   logic [STAGES-1:0]  ch_co, ch_msb;

   assign out_valid = vld_q[L];
   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;
   assign s         = sum_q[L];
   assign c_o       = cy_q[L];
   assign ovf       = cmsb_q ^ cy_q[L];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign a_src[k] = a;
         assign b_src[k] = sub ? ~b : b;
         assign c_src[k] = sub | c_i;
         assign v_src[k] = in_valid;
         assign s_src[k] = '0;
      end else begin : g_tail
         assign a_src[k] = a_q[k-1];
         assign b_src[k] = b_q[k-1];
         assign c_src[k] = cy_q[k-1];
         assign v_src[k] = vld_q[k-1];
         assign s_src[k] = sum_q[k-1];
      end

      rca_chunk #(
         .CHUNK(CW)
      ) u_chunk (
         .a    (a_src[k][k*CW +: CW]),
         .b    (b_src[k][k*CW +: CW]),
         .c_i  (c_src[k]),
         .s    (ch_s[k]),
         .c_o  (ch_co[k]),
         .c_msb(ch_msb[k])
      );
   end

   // Next state of every stage: merge this stage's chunk sum into the partial result.
   always_comb begin
      vld_d  = v_src;
      cy_d   = ch_co;
      cmsb_d = ch_msb[L];
      for (int k = 0; k < STAGES; k++) begin
         a_d[k]               = a_src[k];
         b_d[k]               = b_src[k];
         sum_d[k]             = s_src[k];
         sum_d[k][k*CW +: CW] = ch_s[k];
      end
   end

   // Operand bits already consumed are dropped by synthesis; fold them here.
   logic unused_q;
   always_comb begin
      unused_q = ^ch_msb;
      for (int k = 0; k < STAGES; k++) begin
         unused_q = unused_q ^ (^a_q[k]) ^ (^b_q[k]);
      end
   end

   // Stage registers advance together whenever the output can move.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         cy_q   <= '0;
         cmsb_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
         end
      end else if (en) begin
         vld_q  <= vld_d;
         cy_q   <= cy_d;
         cmsb_q <= cmsb_d;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= sum_d[k];
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: three instances
// (STAGES 1/2/4) checked against an arithmetic model.
module tb_pipelined_rca;

   logic       clk = 1'b0;
   logic       rst, in_valid, c_i, sub, out_ready;
   logic [7:0] a, b;
   logic [2:0] in_rdy, o_vld, co_w, ovf_w;
   logic [7:0] s_w [3];
   logic       rdy_all, iv;
   int         tests = 0;
   int         fails = 0;

   assign rdy_all = &in_rdy;
   assign iv      = in_valid & rdy_all;

   always #5 clk = ~clk;

   function automatic int st_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
   endfunction

   // {c_o, ovf, s} from plain integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci, input logic sb);
      int ux, uy, sx, sy, u, sr;
      logic c, v;
      logic [7:0] r;
      ux = x;
      uy = y;
      sx = $signed(x);
      sy = $signed(y);
      if (sb) begin
         u  = ux - uy;
         c  = (ux >= uy);
         sr = sx - sy;
      end else begin
         u  = ux + uy + int'(ci);
         c  = (u > 255);
         sr = sx + sy + int'(ci);
      end
      r = u[7:0];
      v = (sr > 127) || (sr < -128);
      return {c, v, r};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      logic [9:0] q [$];

      pipelined_rca #(
         .WIDTH (8),
         .STAGES(ST)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (iv),
         .in_ready (in_rdy[g]),
         .a        (a),
         .b        (b),
         .c_i      (c_i),
         .sub      (sub),
         .out_valid(o_vld[g]),
         .out_ready(out_ready),
         .s        (s_w[g]),
         .c_o      (co_w[g]),
         .ovf      (ovf_w[g])
      );

      always @(negedge clk) begin
         if (o_vld[g] && out_ready) begin
            check($sformatf("sb_st%0d_pending", ST), 32'(q.size() > 0), 1);
            if (q.size() > 0)
               check($sformatf("sb_st%0d_data", ST),
                     32'({co_w[g], ovf_w[g], s_w[g]}), 32'(q.pop_front()));
         end
         if (rst) q.delete();
         else if (iv && in_rdy[g]) q.push_back(model(a, b, c_i, sub));
      end
   end

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tci, input logic tsub,
                         input logic [7:0] es, input logic ec, input logic eo);
      a         = ta;
      b         = tb_;
      c_i       = tci;
      sub       = tsub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("lat_st%0d_c%0d", st_of(k), n), o_vld[k], n == st_of(k));
            if (n == st_of(k)) begin
               check($sformatf("s_st%0d_%h", st_of(k), ta), s_w[k], es);
               check($sformatf("co_st%0d_%h", st_of(k), ta), co_w[k], ec);
               check($sformatf("ovf_st%0d_%h", st_of(k), ta), ovf_w[k], eo);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent, stall, acc, got_first, arm;
      logic [7:0] hold;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      c_i       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_vld_st%0d", st_of(k)), o_vld[k], 0);
         check($sformatf("rst_s_st%0d", st_of(k)), s_w[k], 0);
         check($sformatf("rst_co_st%0d", st_of(k)), co_w[k], 0);
         check($sformatf("rst_ovf_st%0d", st_of(k)), ovf_w[k], 0);
         check($sformatf("rst_rdy_st%0d", st_of(k)), in_rdy[k], 1);
      end
      @(posedge clk);
      #1;

      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
      run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      sent      = 0;
      stall     = 0;
      got_first = 0;
      arm       = 0;
      hold      = '0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      c_i       = 1'($urandom);
      sub       = 1'($urandom);
      for (int cyc = 0; cyc < 16; cyc++) begin
         in_valid  = (sent < 4);
         out_ready = (stall == 0);
         @(negedge clk);
         if (stall > 0) begin
            check("bp_in_ready", in_rdy[1], 0);
            check("bp_out_valid", o_vld[1], 1);
            if (stall == 3) hold = s_w[1];
            else check("bp_s_hold", s_w[1], hold);
         end
         acc = int'(iv);
         if (got_first == 0 && o_vld[1]) begin
            got_first = 1;
            arm       = 1;
         end
         @(posedge clk);
         #1;
         if (acc != 0) begin
            sent++;
            a   = 8'($urandom);
            b   = 8'($urandom);
            c_i = 1'($urandom);
            sub = 1'($urandom);
         end
         if (stall > 0) stall--;
         if (arm != 0) begin
            stall = 3;
            arm   = 0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_sent", sent, 4);
      check("bp_drain_st1", g_dut[0].q.size(), 0);
      check("bp_drain_st2", g_dut[1].q.size(), 0);
      check("bp_drain_st4", g_dut[2].q.size(), 0);

      a        = 8'($urandom);
      b        = 8'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1 a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            check($sformatf("mrst_vld_st%0d_c%0d", st_of(k), n), o_vld[k], 0);
         @(posedge clk);
         #1;
      end

      for (int cyc = 0; cyc < 80; cyc++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         a         = 8'($urandom);
         b         = 8'($urandom);
         c_i       = 1'($urandom);
         sub       = 1'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("rnd_drain_st1", g_dut[0].q.size(), 0);
      check("rnd_drain_st2", g_dut[1].q.size(), 0);
      check("rnd_drain_st4", g_dut[2].q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
